rvdmi_req_ctrl: RTL and testbench
=================================

Name: rvdmi_req_ctrl

Overview:
DMI request sequencer between the JTAG TAP and the Debug Module bus, running in the tck domain.
- Turns the TAP's single-cycle wr_en/rd_en pulses into a valid/ready request, waits for the DM response, and captures read data.
- Maintains the sticky DMI status reported back through dtmcs.dmistat and the dmi register's op field.
- Clock-domain crossing to the core clock is handled by a separate block downstream.

Parameters:
AWIDTH, 7, DMI address width (matches the TAP)
IDLE_HINT, 3'd1, value driven on idle (dtmcs.idle)
TIMEOUT_CYC, 1023, tck cycles before an outstanding request is abandoned (only with DMI_TIMEOUT_EN)

Ports:
tck  in  1  JTAG clock; all state updates on posedge
trst  in  1  reset, asynchronous, active-low
tap_wr_en  in  1  write request pulse from TAP
tap_rd_en  in  1  read request pulse from TAP
tap_addr  in  AWIDTH  request address
tap_wdata  in  32  write data
tap_rdata  out  32  last successful read data, to TAP rd_data
tap_rd_status  out  2  op status, to TAP rd_status
dmi_reset  in  1  pulse; clears sticky status
dmi_hard_reset  in  1  pulse; aborts outstanding transaction and clears sticky status
dmi_stat  out  2  sticky status, to dtmcs
idle  out  3  constant IDLE_HINT
dm_req_valid  out  1  request valid to DM
dm_req_ready  in  1  DM accepts request
dm_req_op  out  2  1 = read, 2 = write
dm_req_addr  out  AWIDTH  latched address
dm_req_data  out  32  latched write data
dm_rsp_valid  in  1  response pulse from DM
dm_rsp_data  in  32  response read data
dm_rsp_err  in  1  DM reports failure

Behaviour:
- Reset values: FSM = IDLE, sticky = 0, tap_rdata = 0, dm_req_valid = 0, dm_req_op/addr/data = 0.
- FSM states: IDLE, REQ, WAIT_RSP.
  - IDLE -> REQ on an accepted request. Address, data and op are latched, and dm_req_valid rises on the next edge.
  - REQ holds dm_req_valid and the latched fields stable until dm_req_ready is sampled high, then goes to WAIT_RSP with valid dropped.
  - WAIT_RSP -> IDLE on dm_rsp_valid:
    - If dm_rsp_err = 1: sticky = 2.
    - Else, for a read: tap_rdata <= dm_rsp_data.
    - Else, for a write: tap_rdata is unchanged.
- A request is accepted only when FSM = IDLE and sticky = 0.
- Request while FSM != IDLE and sticky = 0: request dropped, sticky = 3 (busy).
- Request while sticky != 0: dropped, with no change to sticky.
- tap_wr_en and tap_rd_en both high in the same cycle: reserved op. Request dropped and sticky = 2 (if sticky is currently 0).
- dm_rsp_valid outside WAIT_RSP is ignored. This includes the cycle of the req handshake.
- tap_rd_status:
  - sticky, if sticky != 0;
  - else 3, if FSM != IDLE;
  - else 0.
- dmi_stat = sticky.
- dmi_reset: sticky <= 0. The FSM is unaffected, so an outstanding transaction completes normally. A request arriving in the same cycle is dropped.
- dmi_hard_reset: FSM <= IDLE, dm_req_valid <= 0, sticky <= 0. Any later response for the aborted transaction is ignored, since it arrives in IDLE. It has priority over dmi_reset, over a request, and over a response in the same cycle.
- Latency:
  - Request pulse at edge N -> dm_req_valid high after edge N+1.
  - Response at edge M -> FSM IDLE and tap_rdata valid after edge M+1.
- trst asserted mid-transaction: immediate return to the reset values; dm_req_valid is deasserted asynchronously.

Optional Feature:
DMI_TIMEOUT_EN
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT_RSP.
  - When it reaches TIMEOUT_CYC: FSM <= IDLE, dm_req_valid <= 0, sticky <= 2. A response in the same cycle loses to the timeout.
  - dmi_hard_reset clears the counter.
- Undefined: no counter; the FSM waits indefinitely for ready/response.

Test Plan:
- Read: tap_rd_en with addr 0x10; DM ready after 2 cycles, rsp_data 0xDEADBEEF one cycle later -> dm_req_op = 1, dm_req_addr = 0x10, tap_rdata = 0xDEADBEEF, tap_rd_status = 0, dmi_stat = 0.
- Write then busy: tap_wr_en with addr 0x04, data 0x1, DM ready held low; second tap_rd_en 3 cycles later -> no second request, dmi_stat = 3, tap_rd_status = 3. After the write completes and dmi_reset is pulsed -> dmi_stat = 0 and a new read is accepted.
- Error: read answered with dm_rsp_err = 1 -> dmi_stat = 2, tap_rdata unchanged, next request dropped until dmi_reset.
- Reserved op: tap_wr_en and tap_rd_en in the same cycle -> dm_req_valid stays 0, dmi_stat = 2.
- Hard reset: dmi_hard_reset in WAIT_RSP, then a late dm_rsp_valid with data 0x55 -> FSM IDLE, tap_rdata unchanged, dmi_stat = 0, next read accepted.
- Timeout (DMI_TIMEOUT_EN, TIMEOUT_CYC = 8): DM never ready -> dm_req_valid falls after 8 cycles, dmi_stat = 2. Without the macro -> valid held for 100 cycles.

Source files
------------

// File: rtl/rvdmi_req_ctrl.sv
// DMI request sequencer (tck domain): TAP pulses -> DM valid/ready request, response capture, sticky dmistat.
// Optional DMI_TIMEOUT_EN macro adds an abandon timer on outstanding requests.
module rvdmi_req_ctrl #(
  parameter int         AWIDTH      = 7,
  parameter logic [2:0] IDLE_HINT   = 3'd1,
  parameter int         TIMEOUT_CYC = 1023
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              tap_wr_en,
  input  logic              tap_rd_en,
  input  logic [AWIDTH-1:0] tap_addr,
  input  logic [31:0]       tap_wdata,
  output logic [31:0]       tap_rdata,
  output logic [1:0]        tap_rd_status,
  input  logic              dmi_reset,
  input  logic              dmi_hard_reset,
  output logic [1:0]        dmi_stat,
  output logic [2:0]        idle,
  output logic              dm_req_valid,
  input  logic              dm_req_ready,
  output logic [1:0]        dm_req_op,
  output logic [AWIDTH-1:0] dm_req_addr,
  output logic [31:0]       dm_req_data,
  input  logic              dm_rsp_valid,
  input  logic [31:0]       dm_rsp_data,
  input  logic              dm_rsp_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd2;
  localparam logic [1:0] ST_BUSY  = 2'd3;

  state_t            state, state_nxt;
  logic [1:0]        sticky, sticky_nxt;
  logic [31:0]       rdata_nxt;
  logic              valid_nxt;
  logic [1:0]        op_nxt;
  logic [AWIDTH-1:0] addr_nxt;
  logic [31:0]       data_nxt;
  logic              accept;

`ifdef DMI_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_cnt, tmo_cnt_nxt;
`endif

  always_comb begin
    state_nxt = state;
    valid_nxt = dm_req_valid;
    op_nxt    = dm_req_op;
    addr_nxt  = dm_req_addr;
    data_nxt  = dm_req_data;
    rdata_nxt = tap_rdata;
    accept    = 1'b0;
    // dmi_reset clears what was sticky before this cycle; new events may still set it
    sticky_nxt = dmi_reset ? 2'd0 : sticky;

    case (state)
      ST_REQ: begin
        if (dm_req_ready) begin
          state_nxt = ST_WAIT;
          valid_nxt = 1'b0;
        end
      end
      ST_WAIT: begin
        if (dm_rsp_valid) begin
          state_nxt = ST_IDLE;
          if (dm_rsp_err) begin
            sticky_nxt = ST_ERR;
          end else if (dm_req_op == OP_READ) begin
            rdata_nxt = dm_rsp_data;
          end
        end
      end
      default: ;
    endcase

    if ((tap_wr_en || tap_rd_en) && !dmi_reset && (sticky == 2'd0)) begin
      if (tap_wr_en && tap_rd_en) begin
        sticky_nxt = ST_ERR;
      end else if (state != ST_IDLE) begin
        sticky_nxt = ST_BUSY;
      end else begin
        accept    = 1'b1;
        state_nxt = ST_REQ;
        valid_nxt = 1'b1;
        op_nxt    = tap_wr_en ? OP_WRITE : OP_READ;
        addr_nxt  = tap_addr;
        data_nxt  = tap_wdata;
      end
    end

`ifdef DMI_TIMEOUT_EN
    tmo_cnt_nxt = tmo_cnt;
    if (accept) begin
      tmo_cnt_nxt = '0;
    end else if (state != ST_IDLE) begin
      tmo_cnt_nxt = tmo_cnt + 1'b1;
      // the edge on which the count would reach TIMEOUT_CYC abandons the request
      if (tmo_cnt == CW'(TIMEOUT_CYC - 1)) begin
        state_nxt  = ST_IDLE;
        valid_nxt  = 1'b0;
        sticky_nxt = ST_ERR;
        rdata_nxt  = tap_rdata;
      end
    end
`endif

    if (dmi_hard_reset) begin
      state_nxt  = ST_IDLE;
      valid_nxt  = 1'b0;
      sticky_nxt = 2'd0;
      rdata_nxt  = tap_rdata;
`ifdef DMI_TIMEOUT_EN
      tmo_cnt_nxt = '0;
`endif
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state        <= ST_IDLE;
      sticky       <= 2'd0;
      tap_rdata    <= 32'd0;
      dm_req_valid <= 1'b0;
      dm_req_op    <= 2'd0;
      dm_req_addr  <= '0;
      dm_req_data  <= 32'd0;
    end else begin
      state        <= state_nxt;
      sticky       <= sticky_nxt;
      tap_rdata    <= rdata_nxt;
      dm_req_valid <= valid_nxt;
      dm_req_op    <= op_nxt;
      dm_req_addr  <= addr_nxt;
      dm_req_data  <= data_nxt;
    end
  end

`ifdef DMI_TIMEOUT_EN
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt_nxt;
    end
  end
`endif

  always_comb begin
    if (sticky != 2'd0) begin
      tap_rd_status = sticky;
    end else if (state != ST_IDLE) begin
      tap_rd_status = ST_BUSY;
    end else begin
      tap_rd_status = 2'd0;
    end
  end

  assign dmi_stat = sticky;
  assign idle     = IDLE_HINT;

endmodule

// File: tb/tb_rvdmi_req_ctrl.sv
// Directed bench for rvdmi_req_ctrl with request/read-data scoreboards.
module tb_rvdmi_req_ctrl;

`ifdef DMI_TIMEOUT_EN
  localparam int TCYC = 8;
`else
  localparam int TCYC = 1023;
`endif

  logic        tck = 1'b0;
  logic        trst;
  logic        tap_wr_en, tap_rd_en;
  logic [6:0]  tap_addr;
  logic [31:0] tap_wdata;
  logic [31:0] tap_rdata;
  logic [1:0]  tap_rd_status;
  logic        dmi_reset, dmi_hard_reset;
  logic [1:0]  dmi_stat;
  logic [2:0]  idle;
  logic        dm_req_valid, dm_req_ready;
  logic [1:0]  dm_req_op;
  logic [6:0]  dm_req_addr;
  logic [31:0] dm_req_data;
  logic        dm_rsp_valid;
  logic [31:0] dm_rsp_data;
  logic        dm_rsp_err;

  rvdmi_req_ctrl #(.AWIDTH(7), .IDLE_HINT(3'd1), .TIMEOUT_CYC(TCYC)) dut (
    .tck(tck), .trst(trst),
    .tap_wr_en(tap_wr_en), .tap_rd_en(tap_rd_en), .tap_addr(tap_addr), .tap_wdata(tap_wdata),
    .tap_rdata(tap_rdata), .tap_rd_status(tap_rd_status),
    .dmi_reset(dmi_reset), .dmi_hard_reset(dmi_hard_reset), .dmi_stat(dmi_stat), .idle(idle),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_op(dm_req_op),
    .dm_req_addr(dm_req_addr), .dm_req_data(dm_req_data),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data), .dm_rsp_err(dm_rsp_err)
  );

  always #5 tck = ~tck;

  typedef struct packed {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] data;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] exp_rdata;
  int          checks = 0;
  int          errors = 0;

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic wr, input logic rd, input logic [6:0] a, input logic [31:0] d,
                      input logic expect_accept);
    tap_wr_en = wr;
    tap_rd_en = rd;
    tap_addr  = a;
    tap_wdata = d;
    if (expect_accept) req_q.push_back({(wr ? 2'd2 : 2'd1), a, d});
    tick();
    tap_wr_en = 1'b0;
    tap_rd_en = 1'b0;
  endtask

  task automatic handshake(input int wait_cyc, input logic spurious_rsp);
    req_t e;
    repeat (wait_cyc) tick();
    check("req_valid_held", {31'd0, dm_req_valid}, 32'd1);
    check("sb_req_pending", {31'd0, req_q.size() != 0}, 32'd1);
    if (req_q.size() != 0) begin
      e = req_q.pop_front();
      check("req_op", {30'd0, dm_req_op}, {30'd0, e.op});
      check("req_addr", {25'd0, dm_req_addr}, {25'd0, e.addr});
      check("req_data", dm_req_data, e.data);
    end
    dm_req_ready = 1'b1;
    if (spurious_rsp) begin
      dm_rsp_valid = 1'b1;
      dm_rsp_data  = 32'h0000_0099;
    end
    tick();
    dm_req_ready = 1'b0;
    dm_rsp_valid = 1'b0;
    check("req_valid_drop", {31'd0, dm_req_valid}, 32'd0);
  endtask

  task automatic respond(input logic err, input logic [31:0] d, input logic expect_update);
    if (expect_update) exp_rdata = d;
    rd_q.push_back(exp_rdata);
    dm_rsp_valid = 1'b1;
    dm_rsp_err   = err;
    dm_rsp_data  = d;
    tick();
    dm_rsp_valid = 1'b0;
    dm_rsp_err   = 1'b0;
    check("tap_rdata", tap_rdata, rd_q.pop_front());
  endtask

  task automatic pulse_dmi_reset();
    dmi_reset = 1'b1;
    tick();
    dmi_reset = 1'b0;
    check("dmi_reset_stat", {30'd0, dmi_stat}, 32'd0);
  endtask

  initial begin
    int drops;
    trst = 1'b0;
    tap_wr_en = 1'b0; tap_rd_en = 1'b0; tap_addr = '0; tap_wdata = '0;
    dmi_reset = 1'b0; dmi_hard_reset = 1'b0;
    dm_req_ready = 1'b0; dm_rsp_valid = 1'b0; dm_rsp_data = '0; dm_rsp_err = 1'b0;
    exp_rdata = 32'd0;
    repeat (3) tick();
    check("rst_valid", {31'd0, dm_req_valid}, 32'd0);
    check("rst_stat", {30'd0, dmi_stat}, 32'd0);
    check("rst_rdata", tap_rdata, 32'd0);
    check("rst_status", {30'd0, tap_rd_status}, 32'd0);
    check("rst_op", {30'd0, dm_req_op}, 32'd0);
    check("idle_hint", {29'd0, idle}, 32'd1);
    trst = 1'b1;
    tick();

    // plain read
    send(1'b0, 1'b1, 7'h10, 32'd0, 1'b1);
    check("rd_valid_rise", {31'd0, dm_req_valid}, 32'd1);
    check("rd_busy_status", {30'd0, tap_rd_status}, 32'd3);
    handshake(2, 1'b0);
    respond(1'b0, 32'hDEAD_BEEF, 1'b1);
    check("rd_status", {30'd0, tap_rd_status}, 32'd0);
    check("rd_stat", {30'd0, dmi_stat}, 32'd0);

    // write held off by DM, then a busy read
    send(1'b1, 1'b0, 7'h04, 32'h0000_0001, 1'b1);
    tick(); tick();
    send(1'b0, 1'b1, 7'h05, 32'd0, 1'b0);
    check("busy_stat", {30'd0, dmi_stat}, 32'd3);
    check("busy_status", {30'd0, tap_rd_status}, 32'd3);
    handshake(0, 1'b0);
    respond(1'b0, 32'h0BAD_0BAD, 1'b0);
    check("busy_sticky", {30'd0, tap_rd_status}, 32'd3);
    pulse_dmi_reset();
    send(1'b0, 1'b1, 7'h22, 32'd0, 1'b1);
    handshake(1, 1'b0);
    respond(1'b0, 32'h1234_5678, 1'b1);

    // DM error
    send(1'b0, 1'b1, 7'h30, 32'd0, 1'b1);
    handshake(0, 1'b0);
    respond(1'b1, 32'h0000_0BAD, 1'b0);
    check("err_stat", {30'd0, dmi_stat}, 32'd2);
    check("err_status", {30'd0, tap_rd_status}, 32'd2);
    send(1'b0, 1'b1, 7'h31, 32'd0, 1'b0);
    check("err_drop_valid", {31'd0, dm_req_valid}, 32'd0);
    check("err_stat_kept", {30'd0, dmi_stat}, 32'd2);
    pulse_dmi_reset();

    // reserved op
    send(1'b1, 1'b1, 7'h01, 32'hFFFF_FFFF, 1'b0);
    check("resv_valid", {31'd0, dm_req_valid}, 32'd0);
    check("resv_stat", {30'd0, dmi_stat}, 32'd2);
    pulse_dmi_reset();

    // hard reset in WAIT_RSP, late response ignored
    send(1'b0, 1'b1, 7'h08, 32'd0, 1'b1);
    handshake(0, 1'b0);
    check("wait_status", {30'd0, tap_rd_status}, 32'd3);
    dmi_hard_reset = 1'b1;
    tick();
    dmi_hard_reset = 1'b0;
    check("hard_status", {30'd0, tap_rd_status}, 32'd0);
    check("hard_stat", {30'd0, dmi_stat}, 32'd0);
    respond(1'b0, 32'h0000_0055, 1'b0);
    check("late_rsp_status", {30'd0, tap_rd_status}, 32'd0);
    // response during the handshake cycle must be ignored too
    send(1'b0, 1'b1, 7'h11, 32'd0, 1'b1);
    handshake(0, 1'b1);
    check("spur_rdata", tap_rdata, exp_rdata);
    check("spur_status", {30'd0, tap_rd_status}, 32'd3);
    respond(1'b0, 32'hCAFE_F00D, 1'b1);

    // trst mid-transaction deasserts valid without a clock edge
    send(1'b1, 1'b0, 7'h12, 32'h0000_00AA, 1'b1);
    #2;
    trst = 1'b0;
    #1;
    check("trst_valid", {31'd0, dm_req_valid}, 32'd0);
    check("trst_rdata", tap_rdata, 32'd0);
    check("trst_status", {30'd0, tap_rd_status}, 32'd0);
    req_q.delete();
    exp_rdata = 32'd0;
    tick();
    trst = 1'b1;
    tick();

    // DM never ready
    send(1'b0, 1'b1, 7'h7F, 32'd0, 1'b1);
`ifdef DMI_TIMEOUT_EN
    repeat (TCYC - 1) tick();
    check("tmo_valid_before", {31'd0, dm_req_valid}, 32'd1);
    tick();
    check("tmo_valid_drop", {31'd0, dm_req_valid}, 32'd0);
    check("tmo_stat", {30'd0, dmi_stat}, 32'd2);
    pulse_dmi_reset();
`else
    drops = 0;
    repeat (100) begin
      tick();
      if (!dm_req_valid) drops++;
    end
    check("no_tmo_valid_held", drops, 32'd0);
    dmi_hard_reset = 1'b1;
    tick();
    dmi_hard_reset = 1'b0;
    check("no_tmo_abort", {31'd0, dm_req_valid}, 32'd0);
`endif
    req_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
